// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner.
// Drives one column low at a time and samples the synchronised row lines.
// Whole-matrix snapshots are debounced across consecutive scans.
// A single accepted key produces a code, a valid level and a one-cycle press
// pulse. Multi-key maps are blocked until the whole matrix is released.
module keypad_matrix_scanner #(
  parameter int SCAN_DIVIDER_LOG2 = 2,
  parameter int DEBOUNCE_SCANS    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pulse,
  output logic       multiple_keys,
  output logic [7:0] press_count
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS - 1);
  localparam logic [SCAN_DIVIDER_LOG2-1:0] DWELL_LAST = '1;
  localparam logic [SCAN_DIVIDER_LOG2-1:0] DWELL_ONE  = {{(SCAN_DIVIDER_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_BLOCKED  = 2'd2
  } state_t;

  // Number of pressed keys in a 16-bit matrix map.
  function automatic logic [4:0] f_popcount(input logic [15:0] map);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, map[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest pressed key (meaningful when exactly one is set).
  function automatic logic [3:0] f_key_index(input logic [15:0] map);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [3:0]                   r_row_meta;
  logic [3:0]                   r_row_sync;
  logic [SCAN_DIVIDER_LOG2-1:0] r_dwell;
  logic [1:0]                   r_col_idx;
  logic [3:0]                   r_column;
  logic [15:0]                  r_snapshot;
  logic [15:0]                  r_prev_snapshot;
  logic [15:0]                  r_map;
  logic [3:0]                   r_stable;
  logic                         r_scan_done;
  state_t                       r_state;
  logic [3:0]                   r_key_code;
  logic                         r_key_valid;
  logic                         r_key_pulse;
  logic                         r_multiple_keys;
  logic [7:0]                   r_press_count;

  logic [3:0]  w_rows_pressed;
  logic [1:0]  w_col_next;
  logic        w_dwell_last;
  logic [3:0]  w_stable_next;
  logic        w_accept;
  logic [4:0]  w_pop;
  state_t      w_state_next;
  logic [3:0]  w_key_code_next;
  logic        w_key_valid_next;
  logic        w_key_pulse_next;
  logic [7:0]  w_press_count_next;

  assign w_rows_pressed = ~r_row_sync;
  assign w_col_next     = r_col_idx + 2'd1;
  assign w_dwell_last   = (r_dwell == DWELL_LAST);
  assign w_pop          = f_popcount(r_snapshot);

  // Two-flop synchroniser for the asynchronous row lines (idle high = released).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  // Column dwell timing, column rotation and per-column snapshot capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell     <= '0;
      r_col_idx   <= 2'd0;
      r_column    <= 4'b1110;
      r_snapshot  <= 16'd0;
      r_scan_done <= 1'b0;
    end else if (w_dwell_last) begin
      r_dwell                            <= '0;
      r_col_idx                          <= w_col_next;
      r_column                           <= ~(4'b0001 << w_col_next);
      r_snapshot[{r_col_idx, 2'b00} +: 4] <= w_rows_pressed;
      r_scan_done                        <= (r_col_idx == 2'd3);
    end else begin
      r_dwell     <= r_dwell + DWELL_ONE;
      r_scan_done <= 1'b0;
    end
  end

  // Stability count for the completed scan and the acceptance decision.
  always_comb begin
    w_stable_next = 4'd0;
    if (r_snapshot == r_prev_snapshot) begin
      if (r_stable == STABLE_MAX) begin
        w_stable_next = r_stable;
      end else begin
        w_stable_next = r_stable + 4'd1;
      end
    end else begin
      w_stable_next = 4'd0;
    end
    w_accept = r_scan_done && (w_stable_next == STABLE_MAX);
  end

  // Debounce history: previous snapshot, stable count and accepted map.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_snapshot <= 16'd0;
      r_stable        <= 4'd0;
      r_map           <= 16'd0;
    end else if (r_scan_done) begin
      r_prev_snapshot <= r_snapshot;
      r_stable        <= w_stable_next;
      if (w_accept) begin
        r_map <= r_snapshot;
      end else begin
        r_map <= r_map;
      end
    end else begin
      r_prev_snapshot <= r_prev_snapshot;
      r_stable        <= r_stable;
      r_map           <= r_map;
    end
  end

  // Key FSM next state and next outputs; only an accepted map can move it.
  always_comb begin
    w_state_next       = r_state;
    w_key_code_next    = r_key_code;
    w_key_valid_next   = r_key_valid;
    w_key_pulse_next   = 1'b0;
    w_press_count_next = r_press_count;
    if (w_accept) begin
      case (r_state)
        ST_RELEASED: begin
          if (w_pop == 5'd1) begin
            w_state_next       = ST_PRESSED;
            w_key_code_next    = f_key_index(r_snapshot);
            w_key_valid_next   = 1'b1;
            w_key_pulse_next   = 1'b1;
            w_press_count_next = r_press_count + 8'd1;
          end else if (w_pop >= 5'd2) begin
            w_state_next = ST_BLOCKED;
          end else begin
            w_state_next = ST_RELEASED;
          end
        end
        ST_PRESSED: begin
          if (r_snapshot == 16'd0) begin
            w_state_next     = ST_RELEASED;
            w_key_valid_next = 1'b0;
          end else if (r_snapshot == r_map) begin
            w_state_next = ST_PRESSED;
          end else begin
            w_state_next     = ST_BLOCKED;
            w_key_valid_next = 1'b0;
          end
        end
        ST_BLOCKED: begin
          if (r_snapshot == 16'd0) begin
            w_state_next = ST_RELEASED;
          end else begin
            w_state_next = ST_BLOCKED;
          end
        end
        default: begin
          w_state_next     = ST_RELEASED;
          w_key_valid_next = 1'b0;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Key FSM state register and registered key outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_RELEASED;
      r_key_code      <= 4'd0;
      r_key_valid     <= 1'b0;
      r_key_pulse     <= 1'b0;
      r_multiple_keys <= 1'b0;
      r_press_count   <= 8'd0;
    end else begin
      r_state         <= w_state_next;
      r_key_code      <= w_key_code_next;
      r_key_valid     <= w_key_valid_next;
      r_key_pulse     <= w_key_pulse_next;
      r_multiple_keys <= (w_state_next == ST_BLOCKED);
      r_press_count   <= w_press_count_next;
    end
  end

  assign column        = r_column;
  assign key_code      = r_key_code;
  assign key_valid     = r_key_valid;
  assign key_pulse     = r_key_pulse;
  assign multiple_keys = r_multiple_keys;
  assign press_count   = r_press_count;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner.
// A keypad model turns a 16-bit "keys held" map into row levels. A
// scan-level reference model rebuilds each scan's snapshot from the recorded
// key history, debounces over a queue of recent snapshots and tracks the
// expected key outputs; every cycle the DUT outputs are compared with it.
module tb_keypad_matrix_scanner;

  localparam int DWELL = 4;
  localparam int SCAN  = 4 * DWELL;
  localparam int DEB   = 2;
  localparam int M_REL = 0;
  localparam int M_PRS = 1;
  localparam int M_BLK = 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  row;
  logic [3:0]  column;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pulse;
  logic        multiple_keys;
  logic [7:0]  press_count;
  logic [15:0] keys = 16'd0;

  int n_checks = 0;
  int n_fails  = 0;
  int edge_n   = 0;
  int obs_pulses = 0;
  int m_pulses   = 0;

  logic [15:0] key_hist[$];
  logic [15:0] snap_hist[$];
  int          m_mode;
  logic [3:0]  m_code;
  logic        m_valid;
  logic        m_pulse;
  logic [7:0]  m_count;
  logic [15:0] m_held;

  keypad_matrix_scanner #(
    .SCAN_DIVIDER_LOG2(2),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .row(row),
    .column(column),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_pulse(key_pulse),
    .multiple_keys(multiple_keys),
    .press_count(press_count)
  );

  always #5 clock = ~clock;

  // Keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (column[c] == 1'b0 && keys[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    key_hist.delete();
    snap_hist.delete();
    snap_hist.push_back(16'd0);
    edge_n  = 0;
    m_mode  = M_REL;
    m_code  = 4'd0;
    m_valid = 1'b0;
    m_pulse = 1'b0;
    m_count = 8'd0;
    m_held  = 16'd0;
  endtask

  // Evaluate scan n (1-based): each column reads the keys held two cycles
  // before its sample edge; a map is accepted once DEB snapshots agree.
  task automatic model_scan(input int n);
    logic [15:0] snap;
    logic [15:0] k;
    bit          accept;
    int          e;
    int          cnt;
    snap = 16'd0;
    for (int c = 0; c < 4; c++) begin
      e = SCAN * (n - 1) + DWELL * c + DWELL;
      k = key_hist[e-3];
      snap[c*4 +: 4] = k[c*4 +: 4];
    end
    snap_hist.push_back(snap);
    if (snap_hist.size() > DEB) void'(snap_hist.pop_front());
    accept = (snap_hist.size() == DEB);
    foreach (snap_hist[i]) if (snap_hist[i] != snap) accept = 1'b0;
    if (accept) begin
      cnt = $countones(snap);
      if (m_mode == M_REL) begin
        if (cnt == 1) begin
          m_mode = M_PRS;
          m_held = snap;
          for (int i = 0; i < 16; i++) if (snap[i]) m_code = 4'(i);
          m_valid = 1'b1;
          m_pulse = 1'b1;
          m_count = m_count + 8'd1;
          m_pulses++;
        end else if (cnt >= 2) begin
          m_mode = M_BLK;
        end
      end else if (m_mode == M_PRS) begin
        if (snap == 16'd0) begin
          m_mode  = M_REL;
          m_valid = 1'b0;
        end else if (snap != m_held) begin
          m_mode  = M_BLK;
          m_valid = 1'b0;
        end
      end else begin
        if (snap == 16'd0) m_mode = M_REL;
      end
    end
  endtask

  // One clock: record keys, step the model on accept edges, compare outputs.
  task automatic tick();
    logic [3:0] exp_col;
    int         ci;
    key_hist.push_back(keys);
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    m_pulse = 1'b0;
    if (edge_n > SCAN && (edge_n % SCAN) == 1) model_scan((edge_n - 1) / SCAN);
    ci      = (edge_n / DWELL) % 4;
    exp_col = ~(4'b0001 << ci);
    if (key_pulse === 1'b1) obs_pulses++;
    check_eq("column",        {12'd0, column},        {12'd0, exp_col});
    check_eq("key_code",      {12'd0, key_code},      {12'd0, m_code});
    check_eq("key_valid",     {15'd0, key_valid},     {15'd0, m_valid});
    check_eq("key_pulse",     {15'd0, key_pulse},     {15'd0, m_pulse});
    check_eq("multiple_keys", {15'd0, multiple_keys}, {15'd0, (m_mode == M_BLK)});
    check_eq("press_count",   {8'd0, press_count},    {8'd0, m_count});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset (immediately), check reset values, release on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_column",   {12'd0, column},        16'h000E);
    check_eq("rst_code",     {12'd0, key_code},      16'h0000);
    check_eq("rst_valid",    {15'd0, key_valid},     16'h0000);
    check_eq("rst_pulse",    {15'd0, key_pulse},     16'h0000);
    check_eq("rst_multi",    {15'd0, multiple_keys}, 16'h0000);
    check_eq("rst_count",    {8'd0, press_count},    16'h0000);
    repeat (3) @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    int p0;
    logic [15:0] map;
    #3;
    do_reset();
    run(2 * SCAN);

    // Key 6 held, then released.
    p0 = obs_pulses;
    keys = 16'h0040;
    run(3 * SCAN);
    check_eq("k6_pulses", 16'(obs_pulses - p0), 16'd1);
    check_eq("k6_code", {12'd0, key_code}, 16'd6);
    keys = 16'h0000;
    run(3 * SCAN);
    check_eq("k6_released", {15'd0, key_valid}, 16'd0);

    // Key 9 bouncing every 10 cycles for 5 scans, then steady.
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      run(10);
    end
    keys = 16'h0200;
    run(3 * SCAN);
    check_eq("k9_pulses", 16'(obs_pulses), 16'(m_pulses));
    check_eq("k9_code", {12'd0, key_code}, 16'd9);
    keys = 16'h0000;
    run(3 * SCAN);

    // Key 5, then 10 added, 10 released, all released.
    p0 = obs_pulses;
    keys = 16'h0020;
    run(3 * SCAN);
    keys = 16'h0420;
    run(3 * SCAN);
    check_eq("blk_multi", {15'd0, multiple_keys}, 16'd1);
    check_eq("blk_valid", {15'd0, key_valid}, 16'd0);
    keys = 16'h0020;
    run(3 * SCAN);
    check_eq("blk_hold", {15'd0, multiple_keys}, 16'd1);
    keys = 16'h0000;
    run(3 * SCAN);
    check_eq("blk_clear", {15'd0, multiple_keys}, 16'd0);
    check_eq("blk_pulses", 16'(obs_pulses - p0), 16'd1);

    // 256 single-key presses from a fresh reset: counter wraps to 0.
    do_reset();
    run($urandom_range(0, SCAN - 1));
    p0 = obs_pulses;
    for (int i = 0; i < 256; i++) begin
      keys = 16'd1 << $urandom_range(0, 15);
      run(3 * SCAN);
      keys = 16'h0000;
      run(3 * SCAN);
    end
    check_eq("wrap_pulses", 16'(obs_pulses - p0), 16'd256);
    check_eq("wrap_count", {8'd0, press_count}, 16'd0);

    // Random maps (0..3 keys) held for random durations, incl. short glitches.
    for (int i = 0; i < 60; i++) begin
      map = 16'd0;
      for (int j = $urandom_range(0, 3); j > 0; j--) map[$urandom_range(0, 15)] = 1'b1;
      keys = map;
      run($urandom_range(3, 70));
    end
    keys = 16'h0000;
    run(3 * SCAN);

    // Reset while key 3 is held and valid; it is re-accepted after release.
    keys = 16'h0008;
    run(3 * SCAN);
    check_eq("k3_valid", {15'd0, key_valid}, 16'd1);
    run($urandom_range(1, SCAN - 2));
    do_reset();
    p0 = obs_pulses;
    run(3 * SCAN);
    check_eq("k3_repulse", 16'(obs_pulses - p0), 16'd1);
    check_eq("k3_code", {12'd0, key_code}, 16'd3);
    check_eq("k3_count", {8'd0, press_count}, 16'd1);
    keys = 16'h0000;
    run(3 * SCAN);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 mechanical keypad: drives one column low at a time and reads the four row lines.
- Debounces whole-matrix snapshots and rejects multi-key presses.
- Emits a 4-bit key code with a valid level and a one-cycle press pulse.
- Input-side counterpart of the multiplexed 16-segment display driver: the key code feeds the nybble the display shows.

Parameters:
- SCAN_DIVIDER_LOG2, 2: each column is held for 2^SCAN_DIVIDER_LOG2 clock cycles. Legal range 2..20; minimum 2 covers the 2-flop row synchronizer.
- DEBOUNCE_SCANS, 2: number of consecutive identical full-scan snapshots required before the debounced map updates. Legal range 1..15.

Ports:
- clock  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- row  input  4  raw row lines; asynchronous; active-low (pulled up, key pressed = 0).
- column  output  4  column drives; exactly one bit is 0 (active), the others are 1.
- key_code  output  4  index of the accepted key: column_index*4 + row_index.
- key_valid  output  1  high while exactly one debounced key is held and accepted.
- key_pulse  output  1  one-cycle strobe on acceptance of a new single-key press.
- multiple_keys  output  1  high while in the BLOCKED state.
- press_count  output  8  number of accepted presses; wraps at 8 bits.

Behaviour:
- Reset (asynchronous assert):
  - column=4'b1110 (column index 0); key_code=0; key_valid=0; key_pulse=0; multiple_keys=0; press_count=0.
  - FSM=RELEASED; scan snapshot, previous snapshot and debounced map all 0 (no keys); stable counter=0; dwell counter=0.
  - Reset mid-scan or mid-press drops everything to these values. Scanning restarts at column 0 on the first edge after release.
- Synchronizer: row passes through 2 flops; the inverted result gives pressed=1 per row.
- Scan timing:
  - Dwell counter counts 0..2^SCAN_DIVIDER_LOG2-1.
  - On the last dwell cycle the synchronized rows are written into snapshot bits [col*4 +: 4].
  - The column index then advances 0→1→2→3→0 and column rotates its 0 accordingly.
  - One full scan = 4*2^SCAN_DIVIDER_LOG2 cycles (16 at default).
- Scan end: the column-3 sample edge asserts an internal scan_done for one cycle. On the next edge:
  - If snapshot equals previous snapshot: stable counter increments, saturating at DEBOUNCE_SCANS-1. Otherwise the stable counter clears.
  - Previous snapshot <= snapshot.
  - When (stable counter == DEBOUNCE_SCANS-1) after the update, the map is accepted as debounced. With DEBOUNCE_SCANS=1, every scan is accepted.
- FSM, evaluated only on the edge where a map is accepted; all outputs are registered on that same edge:
  - RELEASED:
    - map popcount==1 → PRESSED; key_code=index; key_valid=1; key_pulse=1 for one cycle; press_count+1.
    - popcount≥2 → BLOCKED.
    - map 0 → stay.
  - PRESSED:
    - map 0 → RELEASED; key_valid=0; key_code holds its last value.
    - map identical → stay; no new pulse.
    - any other nonzero map → BLOCKED; key_valid=0; no pulse.
  - BLOCKED:
    - map 0 → RELEASED.
    - any nonzero map → stay.
    - Rollover is not supported; all keys must be released first.
- Latency: from a clean, stable press, acceptance falls on the scan_done+1 edge of the DEBOUNCE_SCANS-th full scan that contains the press.
- Bounce: any differing snapshot restarts the debounce count. Glitches shorter than one scan that do not straddle a sample edge are ignored.
- press_count wraps 255→0. key_pulse never asserts on consecutive cycles.

Test Plan:
- Reset → column=1110, all outputs 0; after reset_n rises, column steps 1110→1101→1011→0111 every 4 cycles and wraps.
- Hold key 6 (row[2]=0 only while column[1]=0) → key_pulse exactly once after the 2nd full stable scan; key_code=6, key_valid=1, press_count=1. Release → key_valid=0 after 2 clean scans.
- Key 9 with row toggling every 10 cycles for 5 scans, then steady → no pulse during bounce; exactly one pulse once 2 identical scans complete.
- Press key 5, then add key 10 → multiple_keys=1, key_valid=0, no second pulse. Release only 10 → still BLOCKED. Release all → RELEASED, multiple_keys=0.
- 256 clean single-key press/release cycles → press_count returns to 0; exactly 256 pulses counted.
- Assert reset_n low while key 3 is held and valid → immediate reset values. Release reset with the key still held → one fresh pulse with key_code=3 after 2 scans.
